// File: rtl/add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_pipe
// Purpose  : Pipelined two's-complement adder/subtractor. The WIDTH-bit
//            operation is split into STAGES carry-chained chunks, one chunk
//            per cycle, with ZF/SF/OF/carry flags and valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int C_CHUNK = WIDTH / STAGES;

  generate
    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("add_sub_pipe: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // Each stage always works on the low chunk of its operands. The x word is
  // rotated right by one chunk per stage, with the new sum chunk entering at
  // the top, so after STAGES rotations it holds the complete sum in place.
  // The b word is simply shifted right, since its consumed chunks are dead.
  logic [WIDTH-1:0] r_x [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_zf;
  logic             r_sf;
  logic             r_of;

  logic [WIDTH-1:0] w_xi  [STAGES];
  logic [WIDTH-1:0] w_bi  [STAGES];
  logic             w_ci  [STAGES];
  logic             w_vi  [STAGES];
  logic [WIDTH-1:0] w_xo  [STAGES];
  logic [WIDTH-1:0] w_bo  [STAGES];
  logic [C_CHUNK:0] w_add [STAGES];
  logic             w_advance;
  logic             w_unused_bits;

  // Global stall: the whole pipe moves only when the output slot is free.
  assign w_advance = ~r_v[STAGES-1] | out_ready;
  assign in_ready  = w_advance;

  // Per-stage chunk adder plus operand preparation for stage 0.
  always_comb begin
    w_xi  = '{default: '0};
    w_bi  = '{default: '0};
    w_ci  = '{default: 1'b0};
    w_vi  = '{default: 1'b0};
    w_xo  = '{default: '0};
    w_bo  = '{default: '0};
    w_add = '{default: '0};
    w_xi[0] = a;
    w_bi[0] = sub ? ~b : b;
    w_ci[0] = sub;
    w_vi[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_xi[k] = r_x[k-1];
      w_bi[k] = r_b[k-1];
      w_ci[k] = r_c[k-1];
      w_vi[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_add[k] = {1'b0, w_xi[k][C_CHUNK-1:0]} + {1'b0, w_bi[k][C_CHUNK-1:0]}
               + {{C_CHUNK{1'b0}}, w_ci[k]};
      w_xo[k]  = WIDTH'({w_add[k][C_CHUNK-1:0], w_xi[k]} >> C_CHUNK);
      w_bo[k]  = w_bi[k] >> C_CHUNK;
    end
  end

  // Stage registers; the last stage (the output) only loads real results so
  // outputs stay at their reset value until the first operation completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_x[k] <= '0;
        r_b[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_zf <= 1'b0;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_vi[k];
        if ((k < STAGES-1) || w_vi[k]) begin
          r_x[k] <= w_xo[k];
          r_b[k] <= w_bo[k];
          r_c[k] <= w_add[k][C_CHUNK];
        end
      end
      if (w_vi[STAGES-1]) begin
        // The final stage's low chunk holds the operand MSBs.
        r_zf <= ~|w_xo[STAGES-1];
        r_sf <= w_xo[STAGES-1][WIDTH-1];
        r_of <= (w_xi[STAGES-1][C_CHUNK-1] == w_bi[STAGES-1][C_CHUNK-1]) &
                (w_add[STAGES-1][C_CHUNK-1] != w_xi[STAGES-1][C_CHUNK-1]);
      end
    end
  end

  // The b word leaving the final stage has no consumer.
  assign w_unused_bits = ^r_b[STAGES-1];

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_x[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign zf        = r_zf;
  assign sf        = r_sf;
  assign of        = r_of;

endmodule
`default_nettype wire
